// File: rtl/seg7_pkg.sv
// seg7_pkg: shared 7-segment patterns, FSM state type and power-of-ten helper
// Patterns are active-high {g..a}; the display top inverts them for the pins.
package seg7_pkg;
  typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;
  localparam logic [6:0] SEG_DASH = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
    7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111,
    SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK};
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-and-add-3 binary to BCD converter, one bit per cycle
// Ports: clk, reset (sync active-low), start (load value), value, busy,
// done (high during the final shift cycle), bcd (NUM_DIGITS packed BCD digits).
// Digits above NUM_DIGITS are dropped; the result is value mod 10^NUM_DIGITS.
module bin2bcd_seq #(
  parameter int VALUE_W = 32,
  parameter int NUM_DIGITS = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [VALUE_W-1:0]      value,
  output logic                    busy,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd
);
  localparam int CW = $clog2(VALUE_W + 1);
  logic [VALUE_W-1:0] sh;
  logic [CW-1:0] cnt;
  logic [4*NUM_DIGITS-1:0] adj;
  always_comb begin
    adj = bcd;
    for (int i = 0; i < NUM_DIGITS; i++)
      adj[4*i +: 4] = bcd[4*i +: 4] > 4'd4 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
  end
  assign busy = cnt != '0;
  assign done = cnt == CW'(1);
  always_ff @(posedge clk)
    if (!reset) begin
      cnt <= '0;
      sh <= '0;
      bcd <= '0;
    end else if (start) begin
      cnt <= CW'(VALUE_W);
      sh <= value;
      bcd <= '0;
    end else if (busy) begin
      cnt <= cnt - 1'b1;
      {bcd, sh} <= {adj, sh} << 1;
    end
endmodule

// File: rtl/seg7_scan_display.sv
// seg7_scan_display: multiplexed 7-segment display of an unsigned binary value
// Ports: clk, reset (sync active-low), value/in_valid/in_ready (accept handshake),
// blank_lz (leading-zero blanking, captured at accept), done (commit pulse),
// SEG ({g..a} active-low), AN (active-low one-hot digit enable).
// Macro SEG7_DP_EN adds dp input and SEG[7] decimal point (active-low).
module seg7_scan_display import seg7_pkg::*; #(
  parameter int NUM_DIGITS = 8,
  parameter int VALUE_W = 32,
  parameter int CLOCK_FREQ = 25_000_000,
  parameter int REFRESH_HZ = 500
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [VALUE_W-1:0]    value,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  blank_lz,
  output logic                  done,
`ifdef SEG7_DP_EN
  input  logic [NUM_DIGITS-1:0] dp,
  output logic [7:0]            SEG,
`else
  output logic [6:0]            SEG,
`endif
  output logic [NUM_DIGITS-1:0] AN
);
  localparam logic [63:0] LIMIT = pow10(NUM_DIGITS);
  localparam int RAW_DIV = CLOCK_FREQ / (REFRESH_HZ * NUM_DIGITS);
  localparam int TICK_DIV = RAW_DIV > 1 ? RAW_DIV : 1;
  localparam int CNT_W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int IDX_W = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  state_t state, state_n;
  logic accept, conv_busy, conv_done, tick, lead_zero;
  logic [4*NUM_DIGITS-1:0] bcd, digits;
  logic cap_ovf, cap_blank, ovf_r, blank_r;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic [3:0] cur;
  logic [6:0] pat;
  assign accept = in_valid && in_ready;
  bin2bcd_seq #(.VALUE_W(VALUE_W), .NUM_DIGITS(NUM_DIGITS)) u_conv (
    .clk(clk), .reset(reset), .start(accept), .value(value),
    .busy(conv_busy), .done(conv_done), .bcd(bcd)
  );
  always_ff @(posedge clk)
    if (!reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    in_ready = state == IDLE && !conv_busy;
    done = state == COMMIT;
    if (accept) state_n = CONVERT;
    else if (state == CONVERT && conv_done) state_n = COMMIT;
    else if (state == COMMIT) state_n = IDLE;
  end
  // Overflow and blanking are held aside until COMMIT so the visible digits
  // and their rendering flags change together on one edge.
  always_ff @(posedge clk)
    if (!reset) begin
      cap_ovf <= 1'b0;
      cap_blank <= 1'b0;
      digits <= '0;
      ovf_r <= 1'b0;
      blank_r <= 1'b0;
    end else begin
      if (accept) begin
        cap_ovf <= 64'(value) >= LIMIT;
        cap_blank <= blank_lz;
      end
      if (state == COMMIT) begin
        digits <= bcd;
        ovf_r <= cap_ovf;
        blank_r <= cap_blank;
      end
    end
  assign tick = cnt == CNT_W'(TICK_DIV - 1);
  always_ff @(posedge clk)
    if (!reset) begin
      cnt <= '0;
      idx <= '0;
    end else if (tick) begin
      cnt <= '0;
      idx <= idx == IDX_W'(NUM_DIGITS - 1) ? '0 : idx + 1'b1;
    end else cnt <= cnt + 1'b1;
  assign cur = 4'(digits >> {idx, 2'b00});
  // A digit is a leading zero when it and every digit above it are zero.
  assign lead_zero = blank_r && idx != '0 && (digits >> {idx, 2'b00}) == '0;
  assign pat = ovf_r ? SEG_DASH : lead_zero ? SEG_BLANK : SEG_TABLE[cur];
  assign AN = ~(NUM_DIGITS'(1) << idx);
`ifdef SEG7_DP_EN
  logic [NUM_DIGITS-1:0] cap_dp, dp_r;
  always_ff @(posedge clk)
    if (!reset) begin
      cap_dp <= '0;
      dp_r <= '0;
    end else begin
      if (accept) cap_dp <= dp;
      if (state == COMMIT) dp_r <= cap_dp;
    end
  assign SEG = {~dp_r[idx], ~pat};
`else
  assign SEG = ~pat;
`endif
endmodule
